// File: rtl/fifo_drain_arb_pkg.sv
// Shared constants, state encoding and sizing helper for the FIFO drain arbiter family.
// No logic of its own; imported by the arbiter top and its round-robin picker.
// Optional statistics are compiled in with FIFO_ARB_STATS_EN (see fifo_drain_arb.sv).
package fifo_drain_arb_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic {
    FIFO_ARB_IDLE  = 1'b0,
    FIFO_ARB_BURST = 1'b1
  } fifo_arb_state_e;

  // Bits needed to index 'value' items; never less than 1.
  function automatic int fifo_arb_log2(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/fifo_drain_arb_rr_pick.sv
// Round-robin picker: first requesting index strictly after 'last', wrapping.
// Latency: purely combinational.
// Backpressure: none; 'found' is low when no request bit is set.
module fifo_drain_arb_rr_pick
  import fifo_drain_arb_pkg::*;
#(
  parameter int N_SRC    = 4,
  parameter int SRC_BITS = 2
) (
  input  logic [N_SRC-1:0]    request,
  input  logic [SRC_BITS-1:0] last,
  output logic                found,
  output logic [SRC_BITS-1:0] index
);

  // Scan last+1, last+2, ... last+N_SRC (the last one being 'last' itself) and keep the first hit.
  always_comb begin
    logic [SRC_BITS-1:0] cand;
    found = FALSE;
    index = '0;
    cand  = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = SRC_BITS'((int'(last) + k) % N_SRC);
      if (!found && request[cand]) begin
        found = TRUE;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_drain_arb.sv
// Round-robin drain of N_SRC FWFT source FIFOs into one tagged downstream write port.
// Latency: 1-cycle arbitration bubble per burst, then read at t -> registered write at t+1.
// Backpressure: dst_full stalls reads (grant kept); one in-flight write may land after full rises.
// Optional per-source word counters are built only when FIFO_ARB_STATS_EN is defined.
module fifo_drain_arb
  import fifo_drain_arb_pkg::*;
#(
  parameter  int DELAY     = 1,
  parameter  int N_SRC     = 4,
  parameter  int WIDTH     = 16,
  parameter  int BURST_LEN = 4,
  localparam int SRC_BITS  = fifo_arb_log2(N_SRC)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   enable,
  input  logic [N_SRC-1:0]       src_empty,
  input  logic [N_SRC*WIDTH-1:0] src_dout,
  output logic [N_SRC-1:0]       src_rden,
  input  logic                   dst_full,
  output logic                   dst_wren,
  output logic [WIDTH-1:0]       dst_din,
  output logic [SRC_BITS-1:0]    dst_src,
  output logic                   busy,
  input  logic                   stats_clr,
  output logic [N_SRC*32-1:0]    stats
);

  localparam int                     BEAT_BITS  = fifo_arb_log2(BURST_LEN);
  localparam logic [BEAT_BITS-1:0]   BEAT_LAST  = BEAT_BITS'(BURST_LEN - 1);
  localparam logic [SRC_BITS-1:0]    LAST_RESET = SRC_BITS'(N_SRC - 1);

  fifo_arb_state_e       state_q, state_d;
  logic [SRC_BITS-1:0]   grant_q, grant_d;
  logic [SRC_BITS-1:0]   last_q, last_d;
  logic [BEAT_BITS-1:0]  beat_q, beat_d;
  logic                  dst_wren_q, dst_wren_d;
  logic [WIDTH-1:0]      dst_din_q, dst_din_d;
  logic [SRC_BITS-1:0]   dst_src_q, dst_src_d;

  logic                  pick_found;
  logic [SRC_BITS-1:0]   pick_index;
  logic                  grant_empty;
  logic [WIDTH-1:0]      grant_dout;
  logic                  rd_go;

  // DELAY only matters to behavioural models with intra-assignment delays; this RTL has none.
  logic unused_delay;
  assign unused_delay = (DELAY != 0);

  fifo_drain_arb_rr_pick #(
    .N_SRC    (N_SRC),
    .SRC_BITS (SRC_BITS)
  ) u_rr_pick (
    .request (~src_empty),
    .last    (last_q),
    .found   (pick_found),
    .index   (pick_index)
  );

  // Select the granted source's data slice with constant part-selects.
  always_comb begin
    grant_dout = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q == SRC_BITS'(i)) grant_dout = src_dout[i*WIDTH +: WIDTH];
    end
  end

  assign grant_empty = src_empty[grant_q];
  assign rd_go       = (state_q == FIFO_ARB_BURST) && !grant_empty && !dst_full && !RESET;

  // One-hot read strobe to the granted source; forced low while in reset.
  always_comb begin
    src_rden = '0;
    if (rd_go) src_rden[grant_q] = TRUE;
  end

  // Next-state: grant in IDLE, move words and decide burst end in BURST.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    beat_d     = beat_q;
    dst_wren_d = FALSE;
    dst_din_d  = dst_din_q;
    dst_src_d  = dst_src_q;
    case (state_q)
      FIFO_ARB_IDLE: begin
        if (enable && pick_found) begin
          grant_d = pick_index;
          beat_d  = '0;
          state_d = FIFO_ARB_BURST;
        end
      end
      FIFO_ARB_BURST: begin
        if (rd_go) begin
          dst_wren_d = TRUE;
          dst_din_d  = grant_dout;
          dst_src_d  = grant_q;
          beat_d     = beat_q + 1'b1;
          if (beat_q == BEAT_LAST) begin
            state_d = FIFO_ARB_IDLE;
            last_d  = grant_q;
          end
        end else if (grant_empty && !dst_full) begin
          // Source ran dry with room downstream: give the next source a turn.
          state_d = FIFO_ARB_IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = FIFO_ARB_IDLE;
    endcase
  end

  // Controller state and registered downstream outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= FIFO_ARB_IDLE;
      grant_q    <= '0;
      last_q     <= LAST_RESET;
      beat_q     <= '0;
      dst_wren_q <= FALSE;
      dst_din_q  <= '0;
      dst_src_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      beat_q     <= beat_d;
      dst_wren_q <= dst_wren_d;
      dst_din_q  <= dst_din_d;
      dst_src_q  <= dst_src_d;
    end
  end

  assign dst_wren = dst_wren_q;
  assign dst_din  = dst_din_q;
  assign dst_src  = dst_src_q;
  assign busy     = (state_q != FIFO_ARB_IDLE);

`ifdef FIFO_ARB_STATS_EN
  logic [31:0] stats_q [N_SRC];
  logic [31:0] stats_d [N_SRC];

  // Saturating per-source read counters; clear wins over a same-cycle read.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      stats_d[i] = stats_q[i];
      if (stats_clr) stats_d[i] = '0;
      else if (src_rden[i] && (stats_q[i] != 32'hFFFF_FFFF)) stats_d[i] = stats_q[i] + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (RESET) stats_q[i] <= '0;
      else       stats_q[i] <= stats_d[i];
    end
  end

  // Flatten counters onto the stats bus.
  always_comb begin
    stats = '0;
    for (int i = 0; i < N_SRC; i++) stats[i*32 +: 32] = stats_q[i];
  end
`else
  assign stats = '0;
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
`endif

endmodule

// File: tb/tb_fifo_drain_arb.sv
// Bench for fifo_drain_arb: queue-backed FWFT sources, transaction-level reference model,
// directed scenarios with literal expectations, then a randomized soak.
module tb_fifo_drain_arb;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int BLEN  = 4;

  logic            CLK;
  logic            RESET;
  logic            enable;
  logic [N-1:0]    src_empty;
  logic [N*W-1:0]  src_dout;
  logic [N-1:0]    src_rden;
  logic            dst_full;
  logic            dst_wren;
  logic [W-1:0]    dst_din;
  logic [1:0]      dst_src;
  logic            busy;
  logic            stats_clr;
  logic [N*32-1:0] stats;

  fifo_drain_arb #(.DELAY(1), .N_SRC(N), .WIDTH(W), .BURST_LEN(BLEN)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .enable    (enable),
    .src_empty (src_empty),
    .src_dout  (src_dout),
    .src_rden  (src_rden),
    .dst_full  (dst_full),
    .dst_wren  (dst_wren),
    .dst_din   (dst_din),
    .dst_src   (dst_src),
    .busy      (busy),
    .stats_clr (stats_clr),
    .stats     (stats)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Source FIFO contents; front is what the FWFT output shows.
  logic [W-1:0] srcq [N][$];
  int           nseq [N];

  // Reference model: which source holds the grant (-1 = none), words moved, rotation point.
  int           m_cur;
  int           m_last;
  int           m_beats;
  logic         m_wren;
  logic [W-1:0] m_din;
  int           m_src;
  logic [31:0]  m_stats [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      srcq[s].push_back(W'(s * 256 + nseq[s]));
      nseq[s]++;
    end
  endtask

  task automatic clear_srcs();
    for (int s = 0; s < N; s++) srcq[s].delete();
  endtask

  // One clock: drive sources, check read strobe, advance model over the edge, check outputs.
  task automatic step();
    logic [N-1:0] er;
    int           sel;
    for (int s = 0; s < N; s++) begin
      src_empty[s]       = (srcq[s].size() == 0);
      src_dout[s*W +: W] = (srcq[s].size() > 0) ? srcq[s][0] : '0;
    end
    #1;
    er = '0;
    if (!RESET && m_cur >= 0 && !dst_full && srcq[m_cur].size() > 0) er[m_cur] = 1'b1;
    chk("src_rden", 64'(src_rden), 64'(er));
    @(posedge CLK);
    if (RESET) begin
      m_cur = -1; m_last = N - 1; m_beats = 0;
      m_wren = 1'b0; m_din = '0; m_src = 0;
    end else if (m_cur < 0) begin
      m_wren = 1'b0;
      if (enable) begin
        sel = -1;
        for (int k = 1; k <= N; k++)
          if (sel < 0 && srcq[(m_last + k) % N].size() > 0) sel = (m_last + k) % N;
        if (sel >= 0) begin m_cur = sel; m_beats = 0; end
      end
    end else if (er != '0) begin
      m_wren = 1'b1;
      m_din  = srcq[m_cur].pop_front();
      m_src  = m_cur;
      m_beats++;
      if (m_beats == BLEN) begin m_last = m_cur; m_cur = -1; end
    end else begin
      m_wren = 1'b0;
      if (srcq[m_cur].size() == 0 && !dst_full) begin m_last = m_cur; m_cur = -1; end
    end
    for (int s = 0; s < N; s++) begin
`ifdef FIFO_ARB_STATS_EN
      if (RESET || stats_clr) m_stats[s] = '0;
      else if (er[s] && m_stats[s] != 32'hFFFF_FFFF) m_stats[s] = m_stats[s] + 1;
`else
      m_stats[s] = '0;
`endif
    end
    #1;
    chk("dst_wren", 64'(dst_wren), 64'(m_wren));
    chk("dst_din", 64'(dst_din), 64'(m_din));
    chk("dst_src", 64'(dst_src), 64'(m_src));
    chk("busy", 64'(busy), 64'(m_cur >= 0));
    for (int s = 0; s < N; s++) chk("stats", 64'(stats[s*32 +: 32]), 64'(m_stats[s]));
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    clear_srcs();
    step();
    step();
    RESET = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int total, first_c, last_c, cyc, nb, cnt, got;
    logic prev_wren;
    int bsrc [16];
    int blen [16];
    int seen [N];

    RESET = 1'b1; enable = 1'b1; dst_full = 1'b0; stats_clr = 1'b0;
    src_empty = '1; src_dout = '0;
    m_cur = -1; m_last = N - 1; m_beats = 0; m_wren = 1'b0; m_din = '0; m_src = 0;
    for (int s = 0; s < N; s++) begin nseq[s] = 0; m_stats[s] = '0; seen[s] = 0; end

    // Reset state.
    do_reset();
    chk("rst_wren_lit", 64'(dst_wren), 64'd0);
    chk("rst_busy_lit", 64'(busy), 64'd0);
    chk("rst_din_lit", 64'(dst_din), 64'd0);
    chk("rst_stats_lit", 64'(stats[63:0]), 64'd0);

    // Scenario 1: ten words per source, no back-pressure.
    for (int s = 0; s < N; s++) push(s, 10);
    total = 0; first_c = -1; last_c = 0; cyc = 0; nb = 0; prev_wren = 1'b0;
    for (int n = 0; n < 300 && total < 40; n++) begin
      step();
      cyc++;
      if (dst_wren) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        if (!prev_wren && nb < 16) begin bsrc[nb] = int'(dst_src); blen[nb] = 0; nb++; end
        if (nb > 0) blen[nb-1]++;
        chk("s1_word", 64'(dst_din), 64'(int'(dst_src) * 256 + seen[dst_src]));
        seen[dst_src]++;
        total++;
      end
      prev_wren = dst_wren;
    end
    chk("s1_total", 64'(total), 64'd40);
    chk("s1_bursts", 64'(nb), 64'd12);
    for (int b = 0; b < 12 && b < nb; b++) begin
      chk("s1_grant_order", 64'(bsrc[b]), 64'(b % 4));
      chk("s1_burst_len", 64'(blen[b]), 64'((b < 8) ? 4 : 2));
    end
    chk("s1_span", 64'(last_c - first_c + 1), 64'd54);
    for (int s = 0; s < N; s++) chk("s1_per_src", 64'(seen[s]), 64'd10);
    drain(3);
    chk("s1_idle", 64'(busy), 64'd0);
`ifdef FIFO_ARB_STATS_EN
    for (int s = 0; s < N; s++) chk("stats_10_lit", 64'(stats[s*32 +: 32]), 64'd10);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    for (int s = 0; s < N; s++) chk("stats_clr_lit", 64'(stats[s*32 +: 32]), 64'd0);
`else
    for (int s = 0; s < N; s++) chk("stats_off_lit", 64'(stats[s*32 +: 32]), 64'd0);
`endif

    // Scenario 2: lone source, then rotation past it.
    push(2, 3);
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (dst_wren) begin cnt++; chk("s2_src", 64'(dst_src), 64'd2); end
    end
    chk("s2_count", 64'(cnt), 64'd3);
    chk("s2_idle", 64'(busy), 64'd0);
    push(2, 2); push(3, 2);
    got = 0;
    for (int n = 0; n < 20 && got == 0; n++) begin
      step();
      if (dst_wren) begin got = 1; chk("s2_src3_first", 64'(dst_src), 64'd3); end
    end
    chk("s2_saw_word", 64'(got), 64'd1);
    drain(20);

    // Scenario 3: back-pressure in the middle of a burst.
    do_reset();
    push(0, 6);
    cnt = 0;
    for (int n = 0; n < 20 && cnt < 2; n++) begin
      step();
      if (dst_wren) cnt++;
    end
    dst_full = 1'b1;
    got = 0;
    for (int n = 0; n < 5; n++) begin
      step();
      if (dst_wren) got++;
    end
    chk("full_wren_le1", 64'(got <= 1), 64'd1);
    chk("full_held_busy", 64'(busy), 64'd1);
    dst_full = 1'b0;
    cnt = cnt + got;
    for (int n = 0; n < 20; n++) begin
      step();
      if (dst_wren) cnt++;
      if (!busy) break;
    end
    chk("full_burst_len", 64'(cnt), 64'd4);
    for (int n = 0; n < 20; n++) begin
      step();
      if (dst_wren) cnt++;
    end
    chk("full_total", 64'(cnt), 64'd6);

    // Scenario 4: reset in the middle of a src1 burst.
    do_reset();
    push(1, 6);
    cnt = 0;
    for (int n = 0; n < 20 && cnt < 1; n++) begin
      step();
      if (dst_wren) cnt++;
    end
    RESET = 1'b1;
    clear_srcs();
    step();
    chk("rst_mid_wren", 64'(dst_wren), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_rden", 64'(src_rden), 64'd0);
    RESET = 1'b0;
    for (int s = 0; s < N; s++) push(s, 3);
    got = 0;
    for (int n = 0; n < 20 && got == 0; n++) begin
      step();
      if (dst_wren) begin got = 1; chk("rst_first_src0", 64'(dst_src), 64'd0); end
    end
    chk("rst_saw_word", 64'(got), 64'd1);
    drain(40);

    // Scenario 5: enable dropped once the burst has started.
    push(2, 6);
    for (int n = 0; n < 20; n++) begin
      step();
      if (busy) break;
    end
    enable = 1'b0;
    cnt = 0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (dst_wren) cnt++;
      if (!busy) break;
    end
    chk("en_burst_len", 64'(cnt), 64'd4);
    got = 0;
    for (int n = 0; n < 6; n++) begin
      step();
      if (busy || dst_wren) got++;
    end
    chk("en_no_grant", 64'(got), 64'd0);
    enable = 1'b1;
    drain(20);

    // Randomized soak against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int s = 0; s < N; s++)
        if ($urandom_range(0, 3) == 0 && srcq[s].size() < 8) push(s, 1);
      dst_full  = ($urandom_range(0, 9) < 3);
      enable    = ($urandom_range(0, 19) != 0);
      stats_clr = ($urandom_range(0, 99) == 0);
      RESET     = ($urandom_range(0, 499) == 0);
      if (RESET) clear_srcs();
      step();
    end
    RESET = 1'b0; dst_full = 1'b0; enable = 1'b1; stats_clr = 1'b0;
    drain(150);
    got = 0;
    for (int s = 0; s < N; s++) got += srcq[s].size();
    chk("soak_drained", 64'(got), 64'd0);
    chk("soak_idle", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
